// File: rtl/axil_regs_pkg.sv
// Shared constants, read FSM encoding and address-region decode for the
// AXI-Lite register endpoint.
package axil_regs_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        REGION_CTRL     = 2'd0,
        REGION_STAT     = 2'd1,
        REGION_UNMAPPED = 2'd2
    } region_e;

    function automatic region_e decode_region(input logic [31:0] word_idx,
                                              input logic [31:0] num_ctrl,
                                              input logic [31:0] num_stat);
        region_e region;
        region = REGION_UNMAPPED;
        if (word_idx < num_ctrl) begin
            region = REGION_CTRL;
        end else if (word_idx < num_ctrl + num_stat) begin
            region = REGION_STAT;
        end
        return region;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// 32-bit AXI-Lite bundle shared between the control crossbar and its endpoints.
interface axi_lite;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_register_slave.sv
// AXI-Lite endpoint: read/write control register bank plus read-only status
// words, with per-register write and read strobes toward the datapath.
module axil_register_slave
    import axil_regs_pkg::*;
#(
    parameter int NUM_CTRL_REGS = 8,
    parameter int NUM_STAT_REGS = 8,
    parameter int ADDR_WIDTH    = 12
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    axi_lite.slave                     s_axil,
    output logic [NUM_CTRL_REGS*32-1:0] ctrl_regs,
    output logic [NUM_CTRL_REGS-1:0]    ctrl_wr_pulse,
    input  logic [NUM_STAT_REGS*32-1:0] stat_in,
    output logic [NUM_STAT_REGS-1:0]    stat_rd_pulse
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    logic                          aw_held;
    logic                          w_held;
    logic [IDX_W-1:0]              aw_idx_q;
    logic [31:0]                   wdata_q;
    logic [3:0]                    wstrb_q;
    logic                          bvalid;
    logic [1:0]                    bresp;
    logic [NUM_CTRL_REGS-1:0][31:0] ctrl_q;

    rd_state_e                     r_state;
    logic                          rvalid;
    logic [1:0]                    rresp;
    logic [31:0]                   rdata;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          commit;
    logic [31:0]                   wr_word;
    logic [31:0]                   wr_data;
    logic [3:0]                    wr_strb;
    logic [31:0]                   rd_word;
    region_e                       wr_region;
    region_e                       rd_region;
    logic                          unused_ok;

    // Readies come only from held/response state so the host never sees a
    // combinational valid-to-ready path.
    assign s_axil.awready = !aw_held && !bvalid;
    assign s_axil.wready  = !w_held && !bvalid;
    assign s_axil.arready = (r_state == R_IDLE);
    assign s_axil.bvalid  = bvalid;
    assign s_axil.bresp   = bresp;
    assign s_axil.rvalid  = rvalid;
    assign s_axil.rresp   = rresp;
    assign s_axil.rdata   = rdata;
    assign ctrl_regs      = ctrl_q;

    assign aw_hs  = s_axil.awvalid && s_axil.awready;
    assign w_hs   = s_axil.wvalid && s_axil.wready;
    assign ar_hs  = s_axil.arvalid && s_axil.arready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    // A commit may use a freshly handshaking beat, so bypass the latches.
    assign wr_word   = 32'(aw_held ? aw_idx_q : s_axil.awaddr[ADDR_WIDTH-1:2]);
    assign wr_data   = w_held ? wdata_q : s_axil.wdata;
    assign wr_strb   = w_held ? wstrb_q : s_axil.wstrb;
    assign rd_word   = 32'(s_axil.araddr[ADDR_WIDTH-1:2]);
    assign wr_region = decode_region(wr_word, 32'(NUM_CTRL_REGS), 32'(NUM_STAT_REGS));
    assign rd_region = decode_region(rd_word, 32'(NUM_CTRL_REGS), 32'(NUM_STAT_REGS));

    assign unused_ok = ^{s_axil.awprot, s_axil.arprot,
                         s_axil.awaddr[31:ADDR_WIDTH], s_axil.awaddr[1:0],
                         s_axil.araddr[31:ADDR_WIDTH], s_axil.araddr[1:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid        <= 1'b0;
            bresp         <= AXIL_RESP_OKAY;
            ctrl_q        <= '0;
            ctrl_wr_pulse <= '0;
        end else begin
            ctrl_wr_pulse <= '0;
            if (bvalid && s_axil.bready) begin
                bvalid <= 1'b0;
            end
            if (aw_hs) begin
                aw_idx_q <= s_axil.awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                wdata_q <= s_axil.wdata;
                wstrb_q <= s_axil.wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                unique case (wr_region)
                    REGION_CTRL: begin
                        bresp <= AXIL_RESP_OKAY;
                        for (int i = 0; i < NUM_CTRL_REGS; i++) begin
                            if (wr_word == 32'(i)) begin
                                ctrl_wr_pulse[i] <= 1'b1;
                                for (int b = 0; b < 4; b++) begin
                                    if (wr_strb[b]) begin
                                        ctrl_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                                    end
                                end
                            end
                        end
                    end
                    REGION_STAT: bresp <= AXIL_RESP_SLVERR;
                    default:     bresp <= AXIL_RESP_DECERR;
                endcase
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
        end
    end

    // NOTE: ctrl_q updates non-blocking, so a read sampled on the same edge as
    // a commit returns the pre-write value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= R_IDLE;
            rvalid        <= 1'b0;
            rresp         <= AXIL_RESP_OKAY;
            rdata         <= '0;
            stat_rd_pulse <= '0;
        end else begin
            stat_rd_pulse <= '0;
            unique case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state <= R_RESP;
                        rvalid  <= 1'b1;
                        unique case (rd_region)
                            REGION_CTRL: begin
                                rresp <= AXIL_RESP_OKAY;
                                for (int i = 0; i < NUM_CTRL_REGS; i++) begin
                                    if (rd_word == 32'(i)) rdata <= ctrl_q[i];
                                end
                            end
                            REGION_STAT: begin
                                rresp <= AXIL_RESP_OKAY;
                                for (int j = 0; j < NUM_STAT_REGS; j++) begin
                                    if (rd_word == 32'(NUM_CTRL_REGS + j)) begin
                                        rdata            <= stat_in[j*32 +: 32];
                                        stat_rd_pulse[j] <= 1'b1;
                                    end
                                end
                            end
                            default: begin
                                rresp <= AXIL_RESP_DECERR;
                                rdata <= '0;
                            end
                        endcase
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_register_slave.sv
// Directed bench for axil_register_slave: stimulus tasks queue expected
// responses, a negedge monitor pops and compares them on each B/R handshake.
module tb_axil_register_slave;
    import axil_regs_pkg::*;

    localparam int NC = 8;
    localparam int NS = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [NC*32-1:0] ctrl_regs;
    logic [NC-1:0]    ctrl_wr_pulse;
    logic [NS*32-1:0] stat_in;
    logic [NS-1:0]    stat_rd_pulse;

    axi_lite bus ();

    axil_register_slave #(
        .NUM_CTRL_REGS(NC),
        .NUM_STAT_REGS(NS),
        .ADDR_WIDTH   (12)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axil       (bus),
        .ctrl_regs    (ctrl_regs),
        .ctrl_wr_pulse(ctrl_wr_pulse),
        .stat_in      (stat_in),
        .stat_rd_pulse(stat_rd_pulse)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  exp_b[$];
    rd_exp_t     exp_r[$];
    logic [31:0] model[NC];
    logic [1:0]  mon_b;
    rd_exp_t     mon_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ctrl(input string name);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("%s_ctrl%0d", name, i), ctrl_regs[i*32 +: 32], model[i]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_wready",  32'(bus.wready),  32'd1);
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_bresp",   32'(bus.bresp),   32'd0);
        check("rst_rresp",   32'(bus.rresp),   32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_wr_pulse", 32'(ctrl_wr_pulse), 32'd0);
        check("rst_rd_pulse", 32'(stat_rd_pulse), 32'd0);
        check_ctrl("rst");
    endtask

    // order: 0 = AW and W together, 1 = AW one cycle before W, 2 = W before AW
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int order,
                            input logic [1:0] exp_resp, input logic [7:0] exp_pulse);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_fire;
        bit w_fire;
        int cyc = 0;
        int idx;
        exp_b.push_back(exp_resp);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = (order != 2);
        bus.wvalid  = (order != 1);
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge aclk);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(posedge aclk);
            #1;
            if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
            if (aw_done && !w_done) bus.wvalid  = 1'b1;
            if (w_done && !aw_done) bus.awvalid = 1'b1;
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_handshakes_done", 32'(aw_done && w_done), 32'd1);
        check("wr_bvalid_latency", 32'(bus.bvalid), 32'd1);
        check("wr_pulse", 32'(ctrl_wr_pulse), 32'(exp_pulse));
        if (exp_resp == AXIL_RESP_OKAY) begin
            idx = int'(addr[11:2]);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        check_ctrl("wr");
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input logic [7:0] exp_pulse);
        bit fire = 1'b0;
        int cyc = 0;
        exp_r.push_back('{data: exp_data, resp: exp_resp});
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!fire && cyc < 50) begin
            @(negedge aclk);
            fire = bus.arvalid && bus.arready;
            @(posedge aclk);
            #1;
            cyc++;
        end
        bus.arvalid = 1'b0;
        check("rd_handshake_done", 32'(fire), 32'd1);
        check("rd_rvalid_latency", 32'(bus.rvalid), 32'd1);
        check("rd_pulse", 32'(stat_rd_pulse), 32'(exp_pulse));
    endtask

    always @(negedge aclk) begin
        if (aresetn && bus.bvalid && bus.bready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected", 32'd1, 32'd0);
            end else begin
                mon_b = exp_b.pop_front();
                check("bresp", 32'(bus.bresp), 32'(mon_b));
            end
        end
        if (aresetn && bus.rvalid && bus.rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
            end else begin
                mon_r = exp_r.pop_front();
                check("rdata", bus.rdata, mon_r.data);
                check("rresp", 32'(bus.rresp), 32'(mon_r.resp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        for (int j = 0; j < NS; j++) stat_in[j*32 +: 32] = 32'h5000_0000 + 32'(j);
        stat_in[2*32 +: 32] = 32'hA5A5_0001;
        for (int i = 0; i < NC; i++) model[i] = '0;

        repeat (2) @(posedge aclk);
        #1;
        check_reset_outputs();
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Full write with AW leading W, then read back.
        do_write(32'h004, 32'hDEAD_BEEF, 4'hF, 1, AXIL_RESP_OKAY, 8'h02);
        @(posedge aclk); #1;
        check("wr_pulse_one_cycle", 32'(ctrl_wr_pulse), 32'd0);
        do_read(32'h004, 32'hDEAD_BEEF, AXIL_RESP_OKAY, 8'h00);

        // Byte-lane strobes with W leading AW.
        do_write(32'h000, 32'hFFFF_FFFF, 4'hF, 0, AXIL_RESP_OKAY, 8'h01);
        do_write(32'h000, 32'h1234_5678, 4'b0101, 2, AXIL_RESP_OKAY, 8'h01);
        do_read(32'h000, 32'hFF34_FF78, AXIL_RESP_OKAY, 8'h00);

        // Status word 2 at index 10: read pulses, write is refused.
        do_read(32'h028, 32'hA5A5_0001, AXIL_RESP_OKAY, 8'h04);
        @(posedge aclk); #1;
        check("rd_pulse_one_cycle", 32'(stat_rd_pulse), 32'd0);
        do_write(32'h028, 32'h0BAD_0BAD, 4'hF, 0, AXIL_RESP_SLVERR, 8'h00);

        // Unmapped window and address aliasing above bit 11.
        do_read(32'h040, 32'h0000_0000, AXIL_RESP_DECERR, 8'h00);
        do_write(32'h040, 32'h1111_2222, 4'hF, 1, AXIL_RESP_DECERR, 8'h00);
        do_read(32'h1004, 32'hDEAD_BEEF, AXIL_RESP_OKAY, 8'h00);

        // Write response backpressure.
        bus.bready = 1'b0;
        do_write(32'h00C, 32'h600D_CAFE, 4'hF, 0, AXIL_RESP_OKAY, 8'h08);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("bp_awready", 32'(bus.awready), 32'd0);
            check("bp_wready",  32'(bus.wready),  32'd0);
            check("bp_bvalid",  32'(bus.bvalid),  32'd1);
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;

        // Read handshaking on the same edge as a commit to that register.
        do_write(32'h008, 32'h55AA_1234, 4'hF, 0, AXIL_RESP_OKAY, 8'h04);
        @(posedge aclk); #1;
        fork
            do_write(32'h008, 32'h0BAD_F00D, 4'hF, 0, AXIL_RESP_OKAY, 8'h04);
            do_read(32'h008, 32'h55AA_1234, AXIL_RESP_OKAY, 8'h00);
        join
        @(posedge aclk); #1;
        do_read(32'h008, 32'h0BAD_F00D, AXIL_RESP_OKAY, 8'h00);
        @(posedge aclk); #1;

        // Reset with a held AW and an unaccepted read response.
        bus.rready = 1'b0;
        do_read(32'h028, 32'hA5A5_0001, AXIL_RESP_OKAY, 8'h04);
        stat_in[2*32 +: 32] = 32'h0000_FFFF;
        bus.awaddr  = 32'h004;
        bus.awvalid = 1'b1;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        @(negedge aclk);
        check("held_awready", 32'(bus.awready), 32'd0);
        check("held_rvalid",  32'(bus.rvalid),  32'd1);
        check("held_rdata_stable", bus.rdata, 32'hA5A5_0001);
        #1;
        aresetn = 1'b0;
        #1;
        exp_b.delete();
        exp_r.delete();
        for (int i = 0; i < NC; i++) model[i] = '0;
        check_reset_outputs();
        @(negedge aclk);
        aresetn    = 1'b1;
        bus.rready = 1'b1;
        @(posedge aclk); #1;

        // Clean traffic after reset; W first would commit early if AW were stale.
        do_write(32'h01C, 32'hCAFE_F00D, 4'hF, 2, AXIL_RESP_OKAY, 8'h80);
        @(posedge aclk); #1;
        do_read(32'h01C, 32'hCAFE_F00D, AXIL_RESP_OKAY, 8'h00);
        do_read(32'h004, 32'h0000_0000, AXIL_RESP_OKAY, 8'h00);

        drain = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && drain < 20) begin
            @(posedge aclk);
            drain++;
        end
        @(negedge aclk);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
